// File: rtl/pulse_blinker_pkg.sv
// Shared definitions for the pulse blinker: FSM state encoding and sizing helpers
// for the pending-blink counter and the blink timer.
package pulse_blinker_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Saturation value of a pending counter that is w bits wide.
    function automatic int unsigned pend_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The timer only ever holds ON_CYCLES-1 or OFF_CYCLES-1, sized with one spare count.
    function automatic int unsigned timer_w(input int unsigned on_c, input int unsigned off_c);
        return $clog2(max_u(on_c, off_c) + 32'd1);
    endfunction

endpackage

// File: rtl/pulse_blinker_blink_timer.sv
// Loadable down-counter that parks at zero; reports when it has reached zero.
module blink_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_blinker.sv
// Turns 1-cycle event pulses into LED blinks (ON_CYCLES high, OFF_CYCLES low),
// queueing events that arrive mid-blink in a saturating pending counter.
module pulse_blinker
    import pulse_blinker_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 5_000_000,
    parameter int unsigned OFF_CYCLES = 5_000_000,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned       TMR_W    = timer_w(ON_CYCLES, OFF_CYCLES);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));
    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              start;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;

    blink_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    // A blink may begin from IDLE or on the final GAP cycle, so back-to-back blinks skip IDLE.
    always_comb begin
        start = ((state_q == S_IDLE) || ((state_q == S_GAP) && tmr_zero))
                && ((pend_q != '0) || pulse_in);
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ON;
                    tmr_load = 1'b1;
                end
            end
            S_ON: begin
                if (tmr_zero) begin
                    state_d  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            S_GAP: begin
                if (tmr_zero) begin
                    if (start) begin
                        state_d  = S_ON;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A start with nothing queued consumes pulse_in directly; otherwise inc/dec cancel.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (start && (pend_q == '0)) begin
            pend_d = pend_q;
        end else if (pulse_in && start) begin
            pend_d = pend_q;
        end else if (pulse_in) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (start) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign led_out  = (state_q == S_ON);
    assign busy     = (state_q != S_IDLE);
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker with a timeline model (blink start times and
// earliest-next-start edge) checked every cycle, plus hand-computed spot checks.
module tb_pulse_blinker;

    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int PW   = 2;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_in = 1'b0;
    logic          led_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Model state: pending count, sticky overflow, start edge of latest blink,
    // and first edge at which a new blink may begin.
    int m_pend = 0;
    bit m_ovf  = 1'b0;
    int m_s    = -1000;
    int m_next = 0;
    bit m_valid = 1'b0;

    pulse_blinker #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .PEND_W    (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", nm, edge_n, act, exp);
        end
    endtask

    always begin
        bit can, st;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_pend  = 0;
            m_ovf   = 1'b0;
            m_s     = -1000;
            m_next  = edge_n;
            m_valid = 1'b1;
        end else begin
            can = (edge_n >= m_next);
            st  = can && ((m_pend > 0) || pulse_in);
            if (st) begin
                m_s    = edge_n;
                m_next = edge_n + ON + OFF;
            end
            if (st && (m_pend > 0) && !pulse_in) begin
                m_pend--;
            end else if (pulse_in && !st) begin
                if (m_pend < PMAX) m_pend++;
                else m_ovf = 1'b1;
            end
        end
        @(negedge clk);
        if (m_valid) begin
            chk("m_led", int'(led_out), int'((edge_n >= m_s) && (edge_n - m_s < ON)));
            chk("m_busy", int'(busy), int'(edge_n < m_next));
            chk("m_pending", int'(pending), m_pend);
            chk("m_overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = 1'b1;
            step();
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d actual=running required=finished", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pulse_in = 1'b0;
        run_to(2);
        chk("reset_led", int'(led_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_overflow", int'(overflow), 0);
        rst = 1'b0;

        // Single pulse sampled at edge 10.
        run_to(9);
        pulses(1);
        chk("t1_led_on", int'(led_out), 1);
        chk("t1_pending", int'(pending), 0);
        run_to(12);
        chk("t1_led_last", int'(led_out), 1);
        step();
        chk("t1_led_off", int'(led_out), 0);
        chk("t1_busy_gap", int'(busy), 1);
        run_to(14);
        chk("t1_busy_last", int'(busy), 1);
        step();
        chk("t1_idle", int'(busy), 0);

        // Three consecutive pulses at edges 20..22: blinks start 20, 25, 30.
        run_to(19);
        pulses(3);
        chk("t2_pending_peak", int'(pending), 2);
        run_to(25);
        chk("t2_second_blink", int'(led_out), 1);
        chk("t2_pending_after", int'(pending), 1);
        run_to(34);
        chk("t2_busy_end", int'(busy), 1);
        chk("t2_overflow", int'(overflow), 0);
        step();
        chk("t2_idle", int'(busy), 0);

        // Six pulses at edges 41..46: saturation at 3, overflow sticks.
        run_to(40);
        pulses(6);
        chk("t3_pending_sat", int'(pending), 3);
        chk("t3_overflow", int'(overflow), 1);
        run_to(70);
        chk("t3_overflow_sticky", int'(overflow), 1);
        chk("t3_drained", int'(pending), 0);

        // Pulse at 72, then a pulse on the final GAP cycle (edge 77).
        run_to(71);
        pulses(1);
        run_to(76);
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        chk("t4_led_restart", int'(led_out), 1);
        chk("t4_busy_held", int'(busy), 1);

        // Queue two behind a blink, then reset mid-ON at edge 89.
        run_to(85);
        pulses(3);
        chk("t5_pending_pre", int'(pending), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_led", int'(led_out), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_pending", int'(pending), 0);
        chk("t5_overflow", int'(overflow), 0);
        run_to(100);
        chk("t5_quiet", int'(busy), 0);

        // pending=1 plus a fresh pulse on the edge the queued blink starts (106).
        pulses(2);
        chk("t6_pending_one", int'(pending), 1);
        run_to(105);
        pulses(1);
        chk("t6_start_led", int'(led_out), 1);
        chk("t6_pending_keep", int'(pending), 1);
        run_to(111);
        chk("t6_last_blink", int'(led_out), 1);
        chk("t6_drained", int'(pending), 0);
        run_to(120);
        chk("t6_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
